// File: rtl/cache_pkg.sv
// Shared types, sizes and address helpers for the direct-mapped write-through data cache.
package cache_pkg;

    localparam int RISC_DATA  = 32;
    localparam int MAIN_DATA  = 128;
    localparam int ADDR_W     = 10;
    localparam int INDEX_W    = 5;
    localparam int OFF_W      = 2;
    localparam int TAG_W      = ADDR_W - OFF_W - INDEX_W;
    localparam int BLK_W      = ADDR_W - OFF_W;
    localparam int NUM_LINES  = 1 << INDEX_W;
    localparam int MEM_LAT    = 4;
    localparam int BOOT_CYC   = MEM_LAT + 1;
    localparam int BOOT_CNT_W = $clog2(BOOT_CYC);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_WAIT = 2'd3
    } state_e;

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [BLK_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFF_W];
    endfunction

    function automatic logic [RISC_DATA-1:0] word_sel(input logic [MAIN_DATA-1:0] blk,
                                                      input logic [OFF_W-1:0] off);
        return blk[off*RISC_DATA +: RISC_DATA];
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU load/store port and block-memory port of the cache controller.
interface cache_controller_if;
    import cache_pkg::*;

    logic                 cpu_rd;
    logic                 cpu_wr;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [RISC_DATA-1:0] cpu_wdata;
    logic [RISC_DATA-1:0] cpu_rdata;
    logic                 cpu_stall;

    logic                 mem_WE;
    logic                 mem_RE;
    logic [BLK_W-1:0]     mem_A;
    logic [OFF_W-1:0]     mem_word_loc;
    logic [RISC_DATA-1:0] mem_WD;
    logic                 mem_done;
    logic [MAIN_DATA-1:0] mem_RD;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_done, mem_RD,
        output cpu_rdata, cpu_stall, mem_WE, mem_RE, mem_A, mem_word_loc, mem_WD
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_done, mem_RD,
        input  cpu_rdata, cpu_stall, mem_WE, mem_RE, mem_A, mem_word_loc, mem_WD
    );

endinterface

// File: rtl/cache_line_array.sv
// Line storage: data/tag/valid per index, combinational lookup, synchronous fill and word update.
module cache_line_array
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   index_i,
    output logic [MAIN_DATA-1:0] line_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 valid_o,
    input  logic                 fill_i,
    input  logic [MAIN_DATA-1:0] fill_data_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic                 word_wr_i,
    input  logic [OFF_W-1:0]     word_off_i,
    input  logic [RISC_DATA-1:0] word_data_i
);

    logic [MAIN_DATA-1:0] data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    assign line_o  = data_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[index_i] <= 1'b1;
        end
    end

    // Data and tags need no reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            data_q[index_i] <= fill_data_i;
            tag_q[index_i]  <= fill_tag_i;
        end else if (word_wr_i) begin
            data_q[index_i][word_off_i*RISC_DATA +: RISC_DATA] <= word_data_i;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through, write-around cache controller between the load/store unit and block memory.
//   state      | meaning
//   ST_BOOT    | post-reset quiet period, lets an orphaned memory access drain
//   ST_IDLE    | serve read hits, detect misses and stores
//   ST_RD_WAIT | mem_RE held until mem_done, then fill line and bypass word
//   ST_WR_WAIT | mem_WE held until mem_done, then update word on hit
module cache_controller
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_controller_if.master  bus
);

    state_e                  state_q, state_d;
    logic [BOOT_CNT_W-1:0]   boot_cnt_q, boot_cnt_d;

    logic [INDEX_W-1:0]      idx;
    logic [OFF_W-1:0]        off;
    logic [MAIN_DATA-1:0]    line;
    logic [TAG_W-1:0]        line_tag;
    logic                    line_valid;
    logic                    hit;
    logic                    fill;
    logic                    word_wr;
    logic                    stall;
    logic [RISC_DATA-1:0]    rdata;

    assign idx = addr_index(bus.cpu_addr);
    assign off = addr_off(bus.cpu_addr);

    cache_line_array u_lines (
        .clk         (clk),
        .rst         (rst),
        .index_i     (idx),
        .line_o      (line),
        .tag_o       (line_tag),
        .valid_o     (line_valid),
        .fill_i      (fill),
        .fill_data_i (bus.mem_RD),
        .fill_tag_i  (addr_tag(bus.cpu_addr)),
        .word_wr_i   (word_wr),
        .word_off_i  (off),
        .word_data_i (bus.cpu_wdata)
    );

    assign hit = line_valid && (line_tag == addr_tag(bus.cpu_addr));

    assign bus.mem_RE       = (state_q == ST_RD_WAIT);
    assign bus.mem_WE       = (state_q == ST_WR_WAIT);
    assign bus.mem_A        = addr_blk(bus.cpu_addr);
    assign bus.mem_word_loc = off;
    assign bus.mem_WD       = bus.cpu_wdata;
    assign bus.cpu_stall    = stall;
    assign bus.cpu_rdata    = rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        stall      = 1'b1;
        rdata      = '0;
        fill       = 1'b0;
        word_wr    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_CNT_W'(BOOT_CYC - 1)) begin
                    state_d    = ST_IDLE;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // A simultaneous load and store is resolved as a store.
                if (bus.cpu_wr) begin
                    state_d = ST_WR_WAIT;
                end else if (bus.cpu_rd) begin
                    if (hit) begin
                        stall = 1'b0;
                        rdata = word_sel(line, off);
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    stall = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (bus.mem_done) begin
                    stall   = 1'b0;
                    rdata   = word_sel(bus.mem_RD, off);
                    fill    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (bus.mem_done) begin
                    stall   = 1'b0;
                    word_wr = hit;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (rst) begin
            stall   = 1'b1;
            rdata   = '0;
            fill    = 1'b0;
            word_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural block memory, valid/tag reference model, directed and random accesses.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word-addressed memory image plus which tag each line holds.
    logic [31:0] ref_mem   [1024];
    logic        ref_valid [32];
    logic [2:0]  ref_tag   [32];

    // Behavioural block memory, no reset: samples RE/WE, completes after a fixed latency.
    logic [127:0] mem_blk [256];
    bit           mem_loaded = 1'b0;
    logic         mdone_q    = 1'b0;
    logic [127:0] mrd_q      = '0;
    bit           m_busy     = 1'b0;
    int           m_cnt      = 0;

    assign bus.mem_done = mdone_q;
    assign bus.mem_RD   = mrd_q;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++)
                mem_blk[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            mem_loaded <= 1'b1;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                mdone_q <= 1'b1;
                m_busy  <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end else if (mdone_q) begin
            mdone_q <= 1'b0;
        end else if (bus.mem_RE || bus.mem_WE) begin
            m_busy <= 1'b1;
            m_cnt  <= 3;
            mrd_q  <= mem_blk[bus.mem_A];
            if (bus.mem_WE)
                mem_blk[bus.mem_A][bus.mem_word_loc*32 +: 32] <= bus.mem_WD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one access right after a rising edge and follow it to completion.
    task automatic access(input bit wr, input bit rd, input logic [9:0] a, input logic [31:0] wd);
        logic [4:0] idx;
        logic [2:0] tg;
        bit         hit, done;
        int         n_stall, n_re, n_we;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        idx = a[6:2];
        tg  = a[9:7];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        n_stall = 0; n_re = 0; n_we = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_RE) n_re++;
            if (bus.mem_WE) n_we++;
            if (bus.mem_RE || bus.mem_WE) begin
                chk("mem_A", 32'(bus.mem_A), 32'(a[9:2]));
                chk("mem_word_loc", 32'(bus.mem_word_loc), 32'(a[1:0]));
            end
            if (bus.mem_WE) chk("mem_WD", bus.mem_WD, wd);
            if (bus.cpu_stall) begin
                n_stall++;
            end else begin
                done = 1'b1;
                if (!wr) chk("cpu_rdata", bus.cpu_rdata, ref_mem[a]);
            end
        end
        chk("completed", 32'(done), 32'd1);
        chk("stall_cycles", n_stall, (wr || !hit) ? 5 : 0);
        chk("re_cycles", n_re, (!wr && !hit) ? 5 : 0);
        chk("we_cycles", n_we, wr ? 5 : 0);
        @(posedge clk); #1;
        if (wr) begin
            ref_mem[a] = wd;
        end else if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    initial begin
        int n_done;
        logic [9:0] ra;
        rst           = 1'b1;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < 32; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        ref_mem[10'h014] = 32'hAAAA_0001;
        ref_mem[10'h015] = 32'hBBBB_0002;
        ref_mem[10'h016] = 32'hCCCC_0003;
        ref_mem[10'h017] = 32'hDDDD_0004;

        // Reset for two edges, then five quiet boot cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("boot_stall", 32'(bus.cpu_stall), 32'd1);
            chk("boot_re_we", 32'({bus.mem_RE, bus.mem_WE}), 32'd0);
            chk("boot_rdata", bus.cpu_rdata, 32'd0);
        end
        @(negedge clk);
        chk("idle_stall", 32'(bus.cpu_stall), 32'd0);
        @(posedge clk); #1;

        // Cold miss returns word C, then neighbouring word A hits.
        access(1'b0, 1'b1, 10'h016, '0);
        access(1'b0, 1'b1, 10'h014, '0);
        // Write hit updates only the addressed word.
        access(1'b1, 1'b0, 10'h015, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 10'h015, '0);
        access(1'b0, 1'b1, 10'h014, '0);
        access(1'b0, 1'b1, 10'h016, '0);
        access(1'b0, 1'b1, 10'h017, '0);
        // Write miss must not allocate.
        access(1'b1, 1'b0, 10'h3F0, $urandom);
        access(1'b0, 1'b1, 10'h3F0, '0);
        // Conflict on index 5.
        access(1'b0, 1'b1, 10'h096, '0);
        access(1'b0, 1'b1, 10'h016, '0);
        // Load and store together behave as a store.
        access(1'b1, 1'b1, 10'h017, $urandom);
        access(1'b0, 1'b1, 10'h017, '0);

        // Reset in the second RD_WAIT cycle; the memory's late mem_done lands in BOOT.
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 10'h2A1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rd_wait_re", 32'(bus.mem_RE), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cpu_rd = 1'b0;
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.mem_done) n_done++;
            chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
            chk("rst_re_we", 32'({bus.mem_RE, bus.mem_WE}), 32'd0);
        end
        chk("stray_done_seen", n_done, 1);
        @(posedge clk); #1;
        access(1'b0, 1'b1, 10'h2A1, '0);
        access(1'b0, 1'b1, 10'h016, '0);
        access(1'b0, 1'b1, 10'h016, '0);

        // Random traffic over a few indices and tags to mix hits, misses and conflicts.
        for (int n = 0; n < 300; n++) begin
            ra = 10'(($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2: access(1'b1, 1'b0, ra, $urandom);
                3:       access(1'b1, 1'b1, ra, $urandom);
                default: access(1'b0, 1'b1, ra, '0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
